sbox_scheduler: RTL

//  Time-shares one S-box lookup path across all eight DES S-boxes for one round.
//  It takes the 48-bit (expanded R XOR subkey) vector and issues eight 6-bit

---
 rtl/sbox_scheduler.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/sbox_scheduler.sv
// Time-shares one DES S-box lookup path across S1..S8 for a single round,
// issuing eight 6-bit lookups in order and assembling the 32-bit result word.
module sbox_scheduler #(
  parameter int unsigned LOOKUP_LAT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [47:0] data_in,
  output logic [2:0]  sbox_sel,
  output logic [5:0]  sbox_in,
  input  logic [3:0]  sbox_out,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  localparam int unsigned DATA_W   = 48;
  localparam int unsigned CHUNK_W  = 6;
  localparam int unsigned NIB_W    = 4;
  localparam int unsigned RES_W    = 32;
  localparam int unsigned SEL_W    = 3;
  localparam int unsigned WCNT_W   = 2;
  localparam int unsigned NUM_BOX  = 8;
  localparam int unsigned LAST_IDX = NUM_BOX - 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    idx_q, idx_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [RES_W-1:0]    result_q, result_d;
  logic [SEL_W-1:0]    sbox_sel_q, sbox_sel_d;
  logic [CHUNK_W-1:0]  sbox_in_q, sbox_in_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                capture;

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      wcnt_q     <= '0;
      data_q     <= '0;
      result_q   <= '0;
      sbox_sel_q <= '0;
      sbox_in_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      wcnt_q     <= wcnt_d;
      data_q     <= data_d;
      result_q   <= result_d;
      sbox_sel_q <= sbox_sel_d;
      sbox_in_q  <= sbox_in_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next-state, nibble capture and look-ahead output computation
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    wcnt_d     = wcnt_q;
    data_d     = data_q;
    result_d   = result_q;
    sbox_sel_d = sbox_sel_q;
    sbox_in_d  = sbox_in_q;
    capture    = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          data_d  = data_in;
          idx_d   = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (LOOKUP_LAT == 0) begin
          capture = 1'b1;
        end else begin
          state_d = S_WAIT;
          wcnt_d  = WCNT_W'(LOOKUP_LAT - 1);
        end
      end
      S_WAIT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (wcnt_q == '0) begin
          capture = 1'b1;
        end else begin
          wcnt_d = WCNT_W'(wcnt_q - 1'b1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (capture) begin
      for (int i = 0; i < NUM_BOX; i++) begin
        if (idx_q == SEL_W'(i)) result_d[RES_W-1-NIB_W*i -: NIB_W] = sbox_out;
      end
      if (idx_q == SEL_W'(LAST_IDX)) begin
        state_d = S_DONE;
      end else begin
        idx_d   = SEL_W'(idx_q + 1'b1);
        state_d = S_ISSUE;
      end
    end

    // Address is computed from the next index/data so it is stable for the whole ISSUE cycle
    if (state_d == S_ISSUE) begin
      sbox_sel_d = idx_d;
      for (int i = 0; i < NUM_BOX; i++) begin
        if (idx_d == SEL_W'(i)) sbox_in_d = data_d[DATA_W-1-CHUNK_W*i -: CHUNK_W];
      end
    end

    busy_d = (state_d == S_ISSUE) || (state_d == S_WAIT);
    done_d = (state_d == S_DONE);
  end

  assign sbox_sel = sbox_sel_q;
  assign sbox_in  = sbox_in_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;

endmodule
